ctrl_flow_seq: RTL and testbench

//  Parametrised control-flow micro-op sequencer in the decode stage. Handles CALL, RET, INT and RTI.

---
 rtl/cf_seq_pkg.sv | 20 ++
 rtl/cf_word_shifter.sv | 25 ++
 rtl/ctrl_flow_seq.sv | 204 ++++++++++++++++++++
 tb/tb_ctrl_flow_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cf_seq_pkg.sv
// Shared types and default micro-op encodings for the control-flow sequencer.
// Pure declarations; no timing or backpressure of its own.
package cf_seq_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_PUSH, S_PUSHF, S_POPF, S_POPF_W, S_POP, S_POP_W, S_REDIRECT
   } state_t;

   typedef enum logic [1:0] {
      OP_CALL = 2'b00, OP_RET = 2'b01, OP_RTI = 2'b10, OP_RSVD = 2'b11
   } req_op_t;

   // Selects where the redirect target comes from.
   typedef enum logic [1:0] {K_CALL, K_INT, K_RET} kind_t;

   localparam int          IDX_W       = 3;
   localparam logic [15:0] DEF_PUSH_OP  = 16'h6008;
   localparam logic [15:0] DEF_POP_OP   = 16'h7008;
   localparam logic [15:0] DEF_PUSHF_OP = 16'h6010;
   localparam logic [15:0] DEF_POPF_OP  = 16'h7010;
endpackage

// File: rtl/cf_word_shifter.sv
// Word view of a PC: selects word i for a push, and merges a popped word into slot i.
// Purely combinational; no handshake.
module cf_word_shifter import cf_seq_pkg::*; #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 16
) (
   input  logic [PC_W-1:0]   push_pc,
   input  logic [IDX_W-1:0]  push_idx,
   output logic [DATA_W-1:0] push_word,
   input  logic [PC_W-1:0]   asm_pc,
   input  logic [IDX_W-1:0]  pop_idx,
   input  logic [DATA_W-1:0] pop_word,
   output logic [PC_W-1:0]   asm_out
);
   localparam int NW = PC_W / DATA_W;

   always_comb begin
      push_word = '0;
      asm_out   = asm_pc;
      for (int i = 0; i < NW; i++) begin
         if (push_idx == IDX_W'(i)) push_word = push_pc[i*DATA_W +: DATA_W];
         if (pop_idx == IDX_W'(i))  asm_out[i*DATA_W +: DATA_W] = pop_word;
      end
   end
endmodule

// File: rtl/ctrl_flow_seq.sv
// CALL/RET/INT/RTI micro-op sequencer: first micro-op one cycle after acceptance, registered outputs.
// Accepts only in IDLE with irq low; pop states wait indefinitely on pop_valid while holding stall.
module ctrl_flow_seq import cf_seq_pkg::*; #(
   parameter int              PC_W       = 32,
   parameter int              DATA_W     = 16,
   parameter int              FLAGS_W    = 4,
   parameter logic [PC_W-1:0] INT_VECTOR = '0,
   parameter logic [DATA_W-1:0] PUSH_OP  = DEF_PUSH_OP,
   parameter logic [DATA_W-1:0] POP_OP   = DEF_POP_OP,
   parameter logic [DATA_W-1:0] PUSHF_OP = DEF_PUSHF_OP,
   parameter logic [DATA_W-1:0] POPF_OP  = DEF_POPF_OP
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   input  logic [1:0]         req_op,
   output logic               req_ready,
   input  logic               irq,
   input  logic [PC_W-1:0]    target,
   input  logic [PC_W-1:0]    ret_pc,
   input  logic [FLAGS_W-1:0] flags_in,
   input  logic               pop_valid,
   input  logic [DATA_W-1:0]  pop_data,
   output logic [DATA_W-1:0]  inject_instr,
   output logic               inject_valid,
   output logic [DATA_W-1:0]  push_data,
   output logic               stall,
   output logic               change_pc,
   output logic [PC_W-1:0]    pc_out,
   output logic               flags_restore,
   output logic [FLAGS_W-1:0] flags_out,
   output logic               busy
);
   localparam int              NW   = PC_W / DATA_W;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NW - 1);

   state_t              state, state_n;
   kind_t               kind, kind_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic [PC_W-1:0]     target_q, target_n, ret_q, ret_n, asm_q, asm_n, asm_merged;
   logic [FLAGS_W-1:0]  flags_q, flags_n;
   logic [DATA_W-1:0]   push_word;

   logic [DATA_W-1:0]   inject_instr_n, push_data_n;
   logic                inject_valid_n, stall_n, change_pc_n, flags_restore_n;
   logic [PC_W-1:0]     pc_out_n;
   logic [FLAGS_W-1:0]  flags_out_n;

   assign req_ready = (state == S_IDLE) & ~irq;

   cf_word_shifter #(.PC_W(PC_W), .DATA_W(DATA_W)) u_shift (
      .push_pc  (ret_n),
      .push_idx (idx_n),
      .push_word(push_word),
      .asm_pc   (asm_q),
      .pop_idx  (idx),
      .pop_word (pop_data),
      .asm_out  (asm_merged)
   );

   always_comb begin
      state_n  = state;
      kind_n   = kind;
      idx_n    = idx;
      target_n = target_q;
      ret_n    = ret_q;
      asm_n    = asm_q;
      flags_n  = flags_q;
      flags_out_n     = flags_out;
      flags_restore_n = 1'b0;

      case (state)
         S_IDLE: begin
            if (irq) begin
               ret_n   = ret_pc;
               flags_n = flags_in;
               kind_n  = K_INT;
               idx_n   = '0;
               state_n = S_PUSH;
            end else if (req_valid) begin
               target_n = target;
               ret_n    = ret_pc;
               flags_n  = flags_in;
               case (req_op)
                  OP_CALL: begin kind_n = K_CALL; idx_n = '0;   state_n = S_PUSH; end
                  OP_RET:  begin kind_n = K_RET;  idx_n = LAST; state_n = S_POP;  end
                  OP_RTI:  begin kind_n = K_RET;  idx_n = LAST; state_n = S_POPF; end
                  default: ;
               endcase
            end
         end
         S_PUSH: begin
            if (idx == LAST) state_n = (kind == K_INT) ? S_PUSHF : S_REDIRECT;
            else             idx_n   = idx + IDX_W'(1);
         end
         S_PUSHF: state_n = S_REDIRECT;
         S_POPF:  state_n = S_POPF_W;
         S_POPF_W: begin
            if (pop_valid) begin
               flags_out_n     = pop_data[FLAGS_W-1:0];
               flags_restore_n = 1'b1;
               idx_n           = LAST;
               state_n         = S_POP;
            end
         end
         S_POP: state_n = S_POP_W;
         S_POP_W: begin
            if (pop_valid) begin
               asm_n = asm_merged;
               if (idx == '0) state_n = S_REDIRECT;
               else begin
                  idx_n   = idx - IDX_W'(1);
                  state_n = S_POP;
               end
            end
         end
         S_REDIRECT: state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
   end

   // Output values are derived from the state being entered so they line up with it once registered.
   always_comb begin
      inject_instr_n = '0;
      inject_valid_n = 1'b0;
      push_data_n    = '0;
      stall_n        = 1'b0;
      change_pc_n    = 1'b0;
      pc_out_n       = pc_out;
      case (state_n)
         S_PUSH: begin
            inject_instr_n = PUSH_OP + DATA_W'(idx_n);
            inject_valid_n = 1'b1;
            push_data_n    = push_word;
            stall_n        = 1'b1;
         end
         S_PUSHF: begin
            inject_instr_n = PUSHF_OP;
            inject_valid_n = 1'b1;
            push_data_n    = DATA_W'(flags_n);
            stall_n        = 1'b1;
         end
         S_POPF: begin
            inject_instr_n = POPF_OP;
            inject_valid_n = 1'b1;
            stall_n        = 1'b1;
         end
         S_POP: begin
            inject_instr_n = POP_OP + DATA_W'(idx_n);
            inject_valid_n = 1'b1;
            push_data_n    = push_word;
            stall_n        = 1'b1;
         end
         S_POPF_W, S_POP_W: stall_n = 1'b1;
         S_REDIRECT: begin
            change_pc_n = 1'b1;
            case (kind_n)
               K_INT:   pc_out_n = INT_VECTOR;
               K_RET:   pc_out_n = asm_n;
               default: pc_out_n = target_n;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         kind          <= K_CALL;
         idx           <= '0;
         target_q      <= '0;
         ret_q         <= '0;
         asm_q         <= '0;
         flags_q       <= '0;
         inject_instr  <= '0;
         inject_valid  <= 1'b0;
         push_data     <= '0;
         stall         <= 1'b0;
         change_pc     <= 1'b0;
         pc_out        <= '0;
         flags_restore <= 1'b0;
         flags_out     <= '0;
         busy          <= 1'b0;
      end else begin
         state         <= state_n;
         kind          <= kind_n;
         idx           <= idx_n;
         target_q      <= target_n;
         ret_q         <= ret_n;
         asm_q         <= asm_n;
         flags_q       <= flags_n;
         inject_instr  <= inject_instr_n;
         inject_valid  <= inject_valid_n;
         push_data     <= push_data_n;
         stall         <= stall_n;
         change_pc     <= change_pc_n;
         pc_out        <= pc_out_n;
         flags_restore <= flags_restore_n;
         flags_out     <= flags_out_n;
         busy          <= (state_n != S_IDLE);
      end
   end
endmodule

// File: tb/tb_ctrl_flow_seq.sv
// Directed bench for ctrl_flow_seq: vector table for basic CALL/RET/reserved, hand sequences for INT, RTI, reset, 64-bit PC.
module tb_ctrl_flow_seq;
   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, irq, pop_valid;
   logic [1:0]  req_op;
   logic [31:0] target, ret_pc, pc_out;
   logic [3:0]  flags_in, flags_out;
   logic [15:0] pop_data, inject_instr, push_data;
   logic        inject_valid, stall, change_pc, flags_restore, busy;

   logic        b_req_valid, b_req_ready, b_pop_valid;
   logic [63:0] b_target, b_ret_pc, b_pc_out;
   logic [15:0] b_inject_instr, b_push_data;
   logic [3:0]  b_flags_out;
   logic        b_inject_valid, b_stall, b_change_pc, b_flags_restore, b_busy;

   ctrl_flow_seq dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
      .irq(irq), .target(target), .ret_pc(ret_pc), .flags_in(flags_in), .pop_valid(pop_valid),
      .pop_data(pop_data), .inject_instr(inject_instr), .inject_valid(inject_valid),
      .push_data(push_data), .stall(stall), .change_pc(change_pc), .pc_out(pc_out),
      .flags_restore(flags_restore), .flags_out(flags_out), .busy(busy)
   );

   ctrl_flow_seq #(.PC_W(64)) dut64 (
      .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_op(2'b00), .req_ready(b_req_ready),
      .irq(1'b0), .target(b_target), .ret_pc(b_ret_pc), .flags_in(4'h0), .pop_valid(b_pop_valid),
      .pop_data(16'h1234), .inject_instr(b_inject_instr), .inject_valid(b_inject_valid),
      .push_data(b_push_data), .stall(b_stall), .change_pc(b_change_pc), .pc_out(b_pc_out),
      .flags_restore(b_flags_restore), .flags_out(b_flags_out), .busy(b_busy)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] tgt;
      logic [31:0] rpc;
      logic [15:0] w0;      // CALL: expected push word 0; RET: popped word for slot 0
      logic [15:0] w1;      // CALL: expected push word 1; RET: popped word for slot 1
      logic [31:0] exp_pc;  // redirect target, or held pc_out for the reserved op
   } vec_t;

   vec_t vecs [5];

   task automatic run_vec(input vec_t v);
      req_op = v.op; target = v.tgt; ret_pc = v.rpc; req_valid = 1'b1;
      #1 chk("vec_ready", 64'(req_ready), 64'd1);
      tick;
      req_valid = 1'b0;
      if (v.op == 2'b00) begin
         chk("call_op0", 64'(inject_instr), 64'h6008);
         chk("call_pd0", 64'(push_data), 64'(v.w0));
         chk("call_stall", 64'({inject_valid, stall}), 64'b11);
         tick;
         chk("call_op1", 64'(inject_instr), 64'h6009);
         chk("call_pd1", 64'(push_data), 64'(v.w1));
         tick;
         chk("call_redir", 64'({change_pc, stall}), 64'b10);
         chk("call_pc", 64'(pc_out), 64'(v.exp_pc));
         tick;
         chk("call_idle", 64'({busy, stall, change_pc}), 64'b000);
      end else if (v.op == 2'b01) begin
         chk("ret_op1", 64'(inject_instr), 64'h7009);
         tick;
         chk("ret_wait1", 64'({inject_valid, stall}), 64'b01);
         pop_valid = 1'b1; pop_data = v.w1;
         tick;
         pop_valid = 1'b0;
         chk("ret_op0", 64'(inject_instr), 64'h7008);
         tick;
         pop_valid = 1'b1; pop_data = v.w0;
         tick;
         pop_valid = 1'b0;
         chk("ret_redir", 64'(change_pc), 64'd1);
         chk("ret_pc", 64'(pc_out), 64'(v.exp_pc));
         tick;
         chk("ret_idle", 64'(busy), 64'd0);
      end else begin
         chk("rsvd_idle", 64'({busy, inject_valid, stall}), 64'b000);
         chk("rsvd_pc_held", 64'(pc_out), 64'(v.exp_pc));
      end
   endtask

   initial begin
      logic seen;
      vecs[0] = '{2'b00, 32'h0000_0F0F, 32'h0000_1234, 16'h1234, 16'h0000, 32'h0000_0F0F};
      vecs[1] = '{2'b00, 32'hDEAD_BEEF, 32'hCAFE_0001, 16'h0001, 16'hCAFE, 32'hDEAD_BEEF};
      vecs[2] = '{2'b01, 32'h0,         32'h0,         16'h1111, 16'h2222, 32'h2222_1111};
      vecs[3] = '{2'b11, 32'h0BAD_0BAD, 32'h0,         16'h0,    16'h0,    32'h2222_1111};
      vecs[4] = '{2'b00, 32'h0,         32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 32'h0};

      reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; irq = 1'b0; target = '0; ret_pc = '0;
      flags_in = '0; pop_valid = 1'b0; pop_data = '0;
      b_req_valid = 1'b0; b_target = '0; b_ret_pc = '0; b_pop_valid = 1'b0;
      tick; tick;
      chk("rst_outs", 64'({busy, stall, change_pc, inject_valid, flags_restore}), 64'd0);
      chk("rst_pc", 64'(pc_out), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd1);
      reset = 1'b1;
      tick;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // RET with slow memory: slot 1 answers after 2 wait cycles, slot 0 after 1.
      req_op = 2'b01; req_valid = 1'b1;
      tick;
      req_valid = 1'b0;
      chk("ret2_op1", 64'(inject_instr), 64'h7009);
      tick;
      chk("ret2_w1a", 64'({inject_valid, stall}), 64'b01);
      tick;
      chk("ret2_w1b", 64'({inject_valid, stall}), 64'b01);
      pop_valid = 1'b1; pop_data = 16'hABCD;
      tick;
      pop_valid = 1'b0;
      chk("ret2_op0", 64'(inject_instr), 64'h7008);
      tick;
      chk("ret2_w0", 64'(stall), 64'd1);
      pop_valid = 1'b1; pop_data = 16'h5678;
      tick;
      pop_valid = 1'b0;
      chk("ret2_pc", 64'({change_pc, pc_out}), {31'd0, 1'b1, 32'hABCD_5678});
      tick;

      // irq beats a simultaneous CALL; the CALL is taken once back in IDLE.
      irq = 1'b1; req_valid = 1'b1; req_op = 2'b00; target = 32'h5555_5555;
      ret_pc = 32'h0000_0100; flags_in = 4'b1010;
      #1 chk("int_ready", 64'(req_ready), 64'd0);
      tick;
      irq = 1'b0;
      chk("int_p0", 64'({inject_instr, push_data}), 64'h6008_0100);
      tick;
      chk("int_p1", 64'({inject_instr, push_data}), 64'h6009_0000);
      tick;
      chk("int_pf", 64'({inject_instr, push_data}), 64'h6010_000A);
      tick;
      chk("int_pc", 64'({change_pc, pc_out}), {31'd0, 1'b1, 32'h0});
      chk("int_redir_ready", 64'(req_ready), 64'd0);
      tick;
      chk("int_after_ready", 64'(req_ready), 64'd1);
      tick;
      req_valid = 1'b0;
      chk("int_call_p0", 64'({inject_instr, push_data}), 64'h6008_0100);
      tick; tick;
      chk("int_call_pc", 64'({change_pc, pc_out}), {31'd0, 1'b1, 32'h5555_5555});
      tick;

      // RTI: flags first, then the two PC words.
      req_op = 2'b10; req_valid = 1'b1;
      tick;
      req_valid = 1'b0;
      chk("rti_popf", 64'({inject_valid, inject_instr}), 64'h1_7010);
      tick;
      chk("rti_wf", 64'({inject_valid, stall}), 64'b01);
      pop_valid = 1'b1; pop_data = 16'h0005;
      tick;
      pop_valid = 1'b0;
      chk("rti_frest", 64'({flags_restore, flags_out}), 64'h15);
      chk("rti_op1", 64'(inject_instr), 64'h7009);
      tick;
      chk("rti_frest_off", 64'(flags_restore), 64'd0);
      pop_valid = 1'b1; pop_data = 16'h0000;
      tick;
      pop_valid = 1'b0;
      tick;
      pop_valid = 1'b1; pop_data = 16'h0200;
      tick;
      pop_valid = 1'b0;
      chk("rti_pc", 64'({change_pc, pc_out}), {31'd0, 1'b1, 32'h0000_0200});
      tick;

      // Reset in the middle of a CALL aborts it without a redirect.
      req_op = 2'b00; target = 32'h0000_0077; ret_pc = 32'h0000_0001; req_valid = 1'b1;
      tick;
      req_valid = 1'b0;
      tick;
      chk("rst5_push1", 64'(inject_instr), 64'h6009);
      #2 reset = 1'b0;
      #1 chk("rst5_outs", 64'({busy, stall, inject_valid, inject_instr, push_data}), 64'd0);
      chk("rst5_pc", 64'(pc_out), 64'd0);
      tick;
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         seen = seen | change_pc;
      end
      chk("rst5_no_redir", 64'(seen), 64'd0);
      target = 32'h0000_0099; ret_pc = 32'h0002_0003; req_valid = 1'b1;
      tick;
      req_valid = 1'b0;
      chk("rst5_p0", 64'({inject_instr, push_data}), 64'h6008_0003);
      tick;
      chk("rst5_p1", 64'({inject_instr, push_data}), 64'h6009_0002);
      tick;
      chk("rst5_pc_new", 64'({change_pc, pc_out}), {31'd0, 1'b1, 32'h0000_0099});
      tick;

      // 64-bit PC: four pushes; a stray pop_valid while idle does nothing.
      b_pop_valid = 1'b1;
      tick;
      b_pop_valid = 1'b0;
      chk("w64_idle_pop", 64'({b_busy, b_stall, b_inject_valid}), 64'd0);
      b_target = 64'h1122_3344_5566_7788; b_ret_pc = 64'h0123_4567_89AB_CDEF; b_req_valid = 1'b1;
      #1 chk("w64_ready", 64'(b_req_ready), 64'd1);
      tick;
      b_req_valid = 1'b0;
      chk("w64_p0", 64'({b_inject_instr, b_push_data}), 64'h6008_CDEF);
      tick;
      chk("w64_p1", 64'({b_inject_instr, b_push_data}), 64'h6009_89AB);
      tick;
      chk("w64_p2", 64'({b_inject_instr, b_push_data}), 64'h600A_4567);
      tick;
      chk("w64_p3", 64'({b_inject_instr, b_push_data}), 64'h600B_0123);
      tick;
      chk("w64_redir", 64'({b_change_pc, b_stall}), 64'b10);
      chk("w64_pc", b_pc_out, 64'h1122_3344_5566_7788);
      tick;
      chk("w64_idle", 64'(b_busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
